// File: rtl/k6502_defs.sv
// k6502_defs: shared encodings for the k6502 core.
//   - one-hot cycle encodings C_N (fetch) .. C_5
//   - IR_BRK, the opcode forced into IR for interrupt sequences
//   - seq_e, the {rst,nmi,irq} sequence-type flag vector fed to mcode
//   - cyc_adv(), the one-hot cycle advance used by the sequencer
package k6502_defs;

  localparam logic [5:0] C_N = 6'b000000;
  localparam logic [5:0] C_0 = 6'b000001;
  localparam logic [5:0] C_1 = 6'b000010;
  localparam logic [5:0] C_2 = 6'b000100;
  localparam logic [5:0] C_3 = 6'b001000;
  localparam logic [5:0] C_4 = 6'b010000;
  localparam logic [5:0] C_5 = 6'b100000;

  localparam logic [7:0] IR_BRK = 8'h00;

  // Bit order matches the {mc_rst, mc_nmi, mc_irq} output vector.
  typedef enum logic [2:0] {
    SEQ_NON = 3'b000,
    SEQ_IRQ = 3'b001,
    SEQ_NMI = 3'b010,
    SEQ_RST = 3'b100
  } seq_e;

  // Step to the next C-cycle. C_5 and any non-one-hot value fall back to
  // fetch so a corrupted counter cannot wedge the core.
  function automatic logic [5:0] cyc_adv(input logic [5:0] c);
    case (c)
      C_0:     return C_1;
      C_1:     return C_2;
      C_2:     return C_3;
      C_3:     return C_4;
      C_4:     return C_5;
      default: return C_N;
    endcase
  endfunction

endpackage

// File: rtl/k6502_irq_sync.sv
// k6502_irq_sync: two-flop synchronizers for the NMI and IRQ pins plus the
// NMI falling-edge detector. Runs every clock regardless of rdy so pin
// activity during a stall is not lost.
//   clk, rst   : core clock, async active-high reset (all flops reset to 1)
//   nmi_n      : NMI pin, active-low, asynchronous
//   irq_n      : IRQ pin, active-low, asynchronous
//   nmi_edge   : 1 for one clock after a synchronized high-to-low NMI edge
//   irq_s      : synchronized IRQ level (active-low)
module k6502_irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n,
  input  logic irq_n,
  output logic nmi_edge,
  output logic irq_s
);

  logic nmi_m, nmi_s, nmi_d;
  logic irq_m;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nmi_m <= 1'b1;
      nmi_s <= 1'b1;
      nmi_d <= 1'b1;
      irq_m <= 1'b1;
      irq_s <= 1'b1;
    end else begin
      nmi_m <= nmi_n;
      nmi_s <= nmi_m;
      nmi_d <= nmi_s;
      irq_m <= irq_n;
      irq_s <= irq_m;
    end
  end

  // Falling edge only: a pin held low yields a single pulse.
  assign nmi_edge = nmi_d & ~nmi_s;

endmodule

// File: rtl/k6502_seq.sv
// k6502_seq: instruction sequencer. Owns IR, the one-hot cycle counter and
// the reset/NMI/IRQ sequence flags that index the microcode ROM.
//   clk, rst    : core clock, async active-high reset
//   rdy         : 1 = advance, 0 = freeze sequencing state
//   nmi_n,irq_n : interrupt pins (active-low, asynchronous)
//   i_flag      : interrupt-disable bit
//   di          : data-in bus (opcode byte at fetch)
//   sync_next   : microcode end-of-sequence bit
//   ir          : instruction register
//   cycle       : one-hot cycle (0 = fetch)
//   mc_rst/nmi/irq : sequence-type flags (at most one high)
//   sync        : high while in the fetch cycle
//   bad_op      : one-clock pulse when the C_5 watchdog fires
import k6502_defs::*;

module k6502_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       i_flag,
  input  logic [7:0] di,
  input  logic       sync_next,
  output logic [7:0] ir,
  output logic [5:0] cycle,
  output logic       mc_rst,
  output logic       mc_nmi,
  output logic       mc_irq,
  output logic       sync,
  output logic       bad_op
);

  logic nmi_edge, irq_s, nmi_pend, take_nmi;
  seq_e seq;

  k6502_irq_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .nmi_edge (nmi_edge),
    .irq_s    (irq_s)
  );

  assign {mc_rst, mc_nmi, mc_irq} = seq;
  assign sync     = ~|cycle;
  assign take_nmi = rdy && (cycle == C_N) && nmi_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= IR_BRK;
      cycle    <= C_0;
      seq      <= SEQ_RST;
      bad_op   <= 1'b0;
      nmi_pend <= 1'b0;
    end else begin
      bad_op   <= 1'b0;
      // Edge capture is independent of rdy; a fresh edge on the consuming
      // clock keeps the latch set so back-to-back NMIs are not merged.
      nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
      if (rdy) begin
        if (cycle == C_N) begin
          cycle <= C_0;
          if (nmi_pend) begin
            seq <= SEQ_NMI;
            ir  <= IR_BRK;
          end else if (!irq_s && !i_flag) begin
            seq <= SEQ_IRQ;
            ir  <= IR_BRK;
          end else begin
            seq <= SEQ_NON;
            ir  <= di;
          end
        end else if (sync_next) begin
          cycle <= C_N;
          seq   <= SEQ_NON;
        end else begin
          // cyc_adv returns C_N from C_5, giving the watchdog abort.
          cycle <= cyc_adv(cycle);
          if (cycle == C_5) begin
            seq    <= SEQ_NON;
            bad_op <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_k6502_seq.sv
module tb_k6502_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rdy = 1'b1;
  logic       nmi_n = 1'b1;
  logic       irq_n = 1'b1;
  logic       i_flag = 1'b0;
  logic [7:0] di = 8'hEA;
  logic       sync_next = 1'b0;
  logic [7:0] ir;
  logic [5:0] cycle;
  logic       mc_rst, mc_nmi, mc_irq, sync, bad_op;

  int asserts = 0;
  int fails   = 0;

  k6502_seq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .nmi_n(nmi_n), .irq_n(irq_n),
    .i_flag(i_flag), .di(di), .sync_next(sync_next), .ir(ir),
    .cycle(cycle), .mc_rst(mc_rst), .mc_nmi(mc_nmi), .mc_irq(mc_irq),
    .sync(sync), .bad_op(bad_op)
  );

  always #5 clk = ~clk;

  // Reference model: cycle index (-1 = fetch, 0..5), sequence kind
  // (0 none, 1 reset, 2 nmi, 3 irq) and pin sample histories
  // (index 0 = sample taken at the most recent edge).
  int         m_cyc;
  int         m_kind;
  logic [7:0] m_ir;
  bit         m_pend, m_bad;
  bit         nh[3];
  bit         ih[3];

  function automatic logic [5:0] m_cycle_vec();
    return (m_cyc < 0) ? 6'd0 : 6'(1 << m_cyc);
  endfunction

  function automatic logic [2:0] m_flags();
    case (m_kind)
      1: return 3'b100;
      2: return 3'b010;
      3: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_kind = 1; m_ir = 8'h00; m_pend = 0; m_bad = 0;
    for (int i = 0; i < 3; i++) begin nh[i] = 1; ih[i] = 1; end
  endtask

  task automatic model_step(input bit sn, input bit rd, input bit nn,
                            input bit in_, input bit ifl, input logic [7:0] d);
    bit edge_seen, irq_lvl, took;
    if (rst) begin model_reset(); return; end
    edge_seen = nh[2] && !nh[1];
    irq_lvl   = ih[1];
    took      = 0;
    m_bad     = 0;
    if (rd) begin
      if (m_cyc < 0) begin
        m_cyc = 0;
        if (m_pend) begin m_kind = 2; m_ir = 8'h00; took = 1; end
        else if (!irq_lvl && !ifl) begin m_kind = 3; m_ir = 8'h00; end
        else begin m_kind = 0; m_ir = d; end
      end else if (sn) begin
        m_cyc = -1; m_kind = 0;
      end else if (m_cyc == 5) begin
        m_cyc = -1; m_kind = 0; m_bad = 1;
      end else begin
        m_cyc++;
      end
    end
    m_pend = edge_seen || (m_pend && !took);
    nh[2] = nh[1]; nh[1] = nh[0]; nh[0] = nn;
    ih[2] = ih[1]; ih[1] = ih[0]; ih[0] = in_;
  endtask

  // Advance one clock; inputs are captured before the edge and outputs are
  // safe to sample 2 time units after it.
  task automatic tick();
    bit sn, rd, nn, in_, ifl;
    logic [7:0] d;
    sn = sync_next; rd = rdy; nn = nmi_n; in_ = irq_n; ifl = i_flag; d = di;
    @(posedge clk);
    model_step(sn, rd, nn, in_, ifl, d);
    #2;
  endtask

  task automatic test_reset();
    logic [5:0] exp_cyc[6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h00};
    model_reset();
    rst = 1'b1; sync_next = 1'b0;
    tick(); tick();
    asserts++;
    if (cycle !== 6'h01 || ir !== 8'h00 || {mc_rst, mc_nmi, mc_irq} !== 3'b100 ||
        bad_op !== 1'b0 || sync !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: cycle=%h ir=%h flags=%b bad=%b sync=%b, want 01 00 100 0 0",
               cycle, ir, {mc_rst, mc_nmi, mc_irq}, bad_op, sync);
    end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      asserts++;
      if (cycle !== exp_cyc[i] || mc_rst !== (i < 5) || sync !== (i == 5)) begin
        fails++;
        $display("FAIL reset_seq[%0d]: cycle=%h mc_rst=%b sync=%b, want %h %b %b",
                 i, cycle, mc_rst, sync, exp_cyc[i], i < 5, i == 5);
      end
      sync_next = (i == 4);
      if (i < 5) tick();
    end
    sync_next = 1'b0;
  endtask

  task automatic test_fetch();
    int clocks = 0;
    di = 8'hA9; sync_next = 1'b0;
    tick(); clocks++;
    asserts++;
    if (ir !== 8'hA9 || cycle !== 6'h01 || sync !== 1'b0) begin
      fails++;
      $display("FAIL fetch_ir: ir=%h cycle=%h sync=%b, want A9 01 0", ir, cycle, sync);
    end
    tick(); clocks++;
    sync_next = 1'b1;
    tick(); clocks++;
    sync_next = 1'b0;
    asserts++;
    if (cycle !== 6'h00 || sync !== 1'b1 || clocks != 3 || ir !== 8'hA9) begin
      fails++;
      $display("FAIL fetch_end: cycle=%h sync=%b clocks=%0d ir=%h, want 00 1 3 A9",
               cycle, sync, clocks, ir);
    end
  endtask

  task automatic test_nmi_irq();
    di = 8'hEA; sync_next = 1'b0;
    tick();                              // fetch, now C_0
    nmi_n = 1'b0; irq_n = 1'b0; i_flag = 1'b0;
    tick(); tick(); tick();              // to C_3
    sync_next = 1'b1; tick();            // to C_N
    sync_next = 1'b0;
    tick();                              // fetch
    asserts++;
    if ({mc_rst, mc_nmi, mc_irq} !== 3'b010 || ir !== 8'h00 || cycle !== 6'h01) begin
      fails++;
      $display("FAIL nmi_first: flags=%b ir=%h cycle=%h, want 010 00 01",
               {mc_rst, mc_nmi, mc_irq}, ir, cycle);
    end
    tick(); sync_next = 1'b1; tick(); sync_next = 1'b0;
    tick();
    asserts++;
    if ({mc_rst, mc_nmi, mc_irq} !== 3'b001 || ir !== 8'h00) begin
      fails++;
      $display("FAIL irq_after_nmi: flags=%b ir=%h, want 001 00", {mc_rst, mc_nmi, mc_irq}, ir);
    end
    i_flag = 1'b1; sync_next = 1'b1; tick(); sync_next = 1'b0;
    tick();
    asserts++;
    if ({mc_rst, mc_nmi, mc_irq} !== 3'b000 || ir !== 8'hEA) begin
      fails++;
      $display("FAIL nmi_no_repeat: flags=%b ir=%h, want 000 EA", {mc_rst, mc_nmi, mc_irq}, ir);
    end
    nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0;
    tick(); tick(); sync_next = 1'b1; tick(); sync_next = 1'b0;
  endtask

  task automatic test_irq_mask();
    irq_n = 1'b0; i_flag = 1'b1; di = 8'hEA; sync_next = 1'b0;
    tick(); tick();
    sync_next = 1'b1; tick(); sync_next = 1'b0;
    tick();
    asserts++;
    if (ir !== 8'hEA || mc_irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_masked: ir=%h mc_irq=%b, want EA 0", ir, mc_irq);
    end
    sync_next = 1'b1; tick(); sync_next = 1'b0;
    i_flag = 1'b0;
    tick();
    asserts++;
    if (ir !== 8'h00 || mc_irq !== 1'b1 || mc_nmi !== 1'b0) begin
      fails++;
      $display("FAIL irq_unmasked: ir=%h mc_irq=%b mc_nmi=%b, want 00 1 0", ir, mc_irq, mc_nmi);
    end
    irq_n = 1'b1;
    tick(); sync_next = 1'b1; tick(); sync_next = 1'b0;
  endtask

  task automatic test_watchdog();
    logic [5:0] exp_cyc[6] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h00};
    di = 8'hFF; sync_next = 1'b0;
    tick();
    asserts++;
    if (ir !== 8'hFF || cycle !== 6'h01) begin
      fails++;
      $display("FAIL wd_fetch: ir=%h cycle=%h, want FF 01", ir, cycle);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      asserts++;
      if (cycle !== exp_cyc[i] || bad_op !== (i == 5)) begin
        fails++;
        $display("FAIL wd_step[%0d]: cycle=%h bad_op=%b, want %h %b",
                 i, cycle, bad_op, exp_cyc[i], i == 5);
      end
    end
    di = 8'hEA;
    tick();
    asserts++;
    if (bad_op !== 1'b0 || cycle !== 6'h01 || ir !== 8'hEA) begin
      fails++;
      $display("FAIL wd_pulse: bad_op=%b cycle=%h ir=%h, want 0 01 EA", bad_op, cycle, ir);
    end
    sync_next = 1'b1; tick(); sync_next = 1'b0;
  endtask

  task automatic test_stall_reset();
    di = 8'hA5; sync_next = 1'b0;
    tick(); tick(); tick();             // C_2
    rdy = 1'b0; nmi_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      asserts++;
      if (cycle !== 6'h04 || ir !== 8'hA5) begin
        fails++;
        $display("FAIL stall[%0d]: cycle=%h ir=%h, want 04 A5", i, cycle, ir);
      end
    end
    asserts++;
    if (dut.nmi_pend !== 1'b1) begin
      fails++;
      $display("FAIL stall_nmi_latch: nmi_pend=%b, want 1", dut.nmi_pend);
    end
    rdy = 1'b1;
    tick();                              // C_3
    rst = 1'b1;
    #1;
    asserts++;
    if (cycle !== 6'h01 || mc_rst !== 1'b1 || ir !== 8'h00 || dut.nmi_pend !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: cycle=%h mc_rst=%b ir=%h nmi_pend=%b, want 01 1 00 0",
               cycle, mc_rst, ir, dut.nmi_pend);
    end
    nmi_n = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    sync_next = 1'b1; tick(); sync_next = 1'b0;
    di = 8'hEA;
    tick();
    asserts++;
    if ({mc_rst, mc_nmi, mc_irq} !== 3'b000 || ir !== 8'hEA) begin
      fails++;
      $display("FAIL nmi_discarded: flags=%b ir=%h, want 000 EA", {mc_rst, mc_nmi, mc_irq}, ir);
    end
    sync_next = 1'b1; tick(); sync_next = 1'b0;
  endtask

  task automatic test_random();
    int errs = 0;
    for (int i = 0; i < 2000; i++) begin
      asserts++;
      if (cycle !== m_cycle_vec() || ir !== m_ir || {mc_rst, mc_nmi, mc_irq} !== m_flags() ||
          sync !== (m_cyc < 0) || bad_op !== m_bad) begin
        fails++;
        errs++;
        if (errs < 10)
          $display("FAIL random[%0d]: cycle=%h ir=%h flags=%b sync=%b bad=%b, want %h %h %b %b %b",
                   i, cycle, ir, {mc_rst, mc_nmi, mc_irq}, sync, bad_op,
                   m_cycle_vec(), m_ir, m_flags(), m_cyc < 0, m_bad);
      end
      rdy       = ($urandom_range(0, 9) < 8);
      sync_next = ($urandom_range(0, 9) < 3);
      di        = 8'($urandom);
      if ($urandom_range(0, 19) == 0) nmi_n  = ~nmi_n;
      if ($urandom_range(0, 19) == 0) irq_n  = ~irq_n;
      if ($urandom_range(0, 9)  == 0) i_flag = ~i_flag;
      tick();
    end
    rdy = 1'b1; nmi_n = 1'b1; irq_n = 1'b1; i_flag = 1'b0; sync_next = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_nmi_irq();
    test_irq_mask();
    test_watchdog();
    test_stall_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
